// File: rtl/reg_bank_16x8_pkg.sv
// rtl/reg_bank_16x8_pkg.sv - shared constants, clear-FSM encoding and helpers for reg_bank_16x8
package reg_bank_16x8_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH      = 16;
    localparam int ADDR_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_e;

    function automatic logic [ADDR_W:0] popcount16(input logic [DEPTH-1:0] v);
        logic [ADDR_W:0] n;
        n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n = n + {{ADDR_W{1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/reg_bank_16x8_onehot_to_idx.sv
// rtl/reg_bank_16x8_onehot_to_idx.sv - 16-bit one-hot to 4-bit index encoder with validity flag
module onehot_to_idx
    import reg_bank_16x8_pkg::*;
(
    input  logic [DEPTH-1:0]  onehot_i,
    output logic [ADDR_W-1:0] idx_o,
    output logic              is_onehot_o
);

    // OR-ing the indices of all set bits is exact for a one-hot input;
    // the result is meaningless otherwise and must be qualified by is_onehot_o.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (onehot_i[i]) begin
                idx_o = idx_o | ADDR_W'(i);
            end
        end
    end

    assign is_onehot_o = (popcount16(onehot_i) == (ADDR_W + 1)'(1));

endmodule

// File: rtl/reg_bank_16x8.sv
// rtl/reg_bank_16x8.sv - 16x8 register bank: one-hot write, registered binary-address read, clear sweep
module reg_bank_16x8
    import reg_bank_16x8_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter logic [DATA_W-1:0] CLR_VAL   = '0
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DEPTH-1:0]  sel,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done,
    output logic              err_sel,
    output logic              wr_drop
);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              clr_we;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              err_sel_q, err_sel_d;
    logic              wr_drop_q, wr_drop_d;

    logic [ADDR_W-1:0] wr_idx;
    logic              sel_ok;
    logic              wr_ok;

    onehot_to_idx u_sel_dec (
        .onehot_i    (sel),
        .idx_o       (wr_idx),
        .is_onehot_o (sel_ok)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter wraps 15 -> 0 on the CLEAR exit, so each sweep starts from entry 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        clr_done = 1'b0;
        clr_we   = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
            end
            ST_DONE: begin
                clr_done = 1'b1;
            end
            default: begin
                busy     = 1'b0;
                clr_done = 1'b0;
                clr_we   = 1'b0;
            end
        endcase
    end

    // wr_en gates every use of sel, so a floating decoder bus is harmless while disabled.
    assign wr_ok     = wr_en & sel_ok & ~busy;
    assign err_sel_d = wr_en & ~sel_ok;
    assign wr_drop_d = wr_en & sel_ok & busy;

    // Host writes and sweep writes are mutually exclusive: host writes are blocked while busy.
    always_comb begin
        mem_d = mem_q;
        if (wr_ok) begin
            mem_d[wr_idx] = wr_data;
        end
        if (clr_we) begin
            mem_d[cnt_q] = CLR_VAL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_VAL;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Reads sample mem_q before this edge's update, giving read-before-write ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_sel_q  <= 1'b0;
            wr_drop_q  <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_data_q <= mem_q[rd_addr];
            end
            rd_valid_q <= rd_en;
            err_sel_q  <= err_sel_d;
            wr_drop_q  <= wr_drop_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign err_sel  = err_sel_q;
    assign wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_reg_bank_16x8.sv
// tb/tb_reg_bank_16x8.sv - directed self-checking bench for reg_bank_16x8
module tb_reg_bank_16x8;

    logic        clk;
    logic        reset;
    logic [15:0] sel;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        clr_req;
    logic        busy;
    logic        clr_done;
    logic        err_sel;
    logic        wr_drop;

    int checks;
    int errors;

    reg_bank_16x8 dut (
        .clk      (clk),
        .reset    (reset),
        .sel      (sel),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_done (clr_done),
        .err_sel  (err_sel),
        .wr_drop  (wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int idx, input logic [7:0] d);
        sel     = 16'h0001 << idx;
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
        sel     = 16'h0000;
    endtask

    task automatic do_read(input logic [3:0] a, output logic [7:0] d, output logic v);
        rd_en   = 1'b1;
        rd_addr = a;
        step();
        rd_en   = 1'b0;
        d       = rd_data;
        v       = rd_valid;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        checks++;
        if ({rd_data, rd_valid, busy, clr_done, err_sel, wr_drop} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h expected %h", {rd_data, rd_valid, busy, clr_done, err_sel, wr_drop}, 13'h0);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset_read_all();
        logic [7:0] d;
        logic       v;
        for (int i = 0; i < 16; i++) begin
            do_read(4'(i), d, v);
            checks++;
            if (d !== 8'h00 || v !== 1'b1) begin
                errors++;
                $display("FAIL reset_read[%0d] got %h/%b expected 00/1", i, d, v);
            end
        end
        rd_addr = 4'd3;
        step();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL idle_read_hold got %h/%b expected 00/0", rd_data, rd_valid);
        end
    endtask

    task automatic test_write_read();
        logic [7:0] d;
        logic       v;
        do_write(5, 8'hA5);
        do_read(4'd5, d, v);
        checks++;
        if (d !== 8'hA5 || v !== 1'b1) begin
            errors++;
            $display("FAIL write_read_5 got %h/%b expected a5/1", d, v);
        end
        do_read(4'd4, d, v);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL neighbour_4 got %h expected 00", d);
        end
        do_read(4'd6, d, v);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL neighbour_6 got %h expected 00", d);
        end
    endtask

    task automatic test_err_sel();
        logic [15:0] bad [2];
        logic [7:0]  d;
        logic        v;
        bad[0] = 16'h0000;
        bad[1] = 16'h0301;
        for (int k = 0; k < 2; k++) begin
            sel     = bad[k];
            wr_en   = 1'b1;
            wr_data = 8'hEE;
            step();
            wr_en   = 1'b0;
            sel     = 16'h0000;
            checks++;
            if (err_sel !== 1'b1 || wr_drop !== 1'b0) begin
                errors++;
                $display("FAIL err_sel_pulse[%h] got %b/%b expected 1/0", bad[k], err_sel, wr_drop);
            end
            step();
            checks++;
            if (err_sel !== 1'b0) begin
                errors++;
                $display("FAIL err_sel_clear[%h] got %b expected 0", bad[k], err_sel);
            end
        end
        for (int i = 0; i < 16; i++) begin
            do_read(4'(i), d, v);
            checks++;
            if (d !== ((i == 5) ? 8'hA5 : 8'h00)) begin
                errors++;
                $display("FAIL err_unchanged[%0d] got %h expected %h", i, d, (i == 5) ? 8'hA5 : 8'h00);
            end
        end
    endtask

    task automatic test_clear_sweep();
        logic [7:0] d;
        logic       v;
        int         busy_cnt;
        int         done_seen;
        for (int i = 0; i < 16; i++) begin
            do_write(i, 8'h10 + 8'(i));
        end
        clr_req = 1'b1;
        step();
        clr_req  = 1'b0;
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        done_seen = 0;
        for (int k = 1; k <= 30; k++) begin
            rd_en = (k == 3);
            rd_addr = 4'd15;
            wr_en = (k == 5);
            sel = (k == 5) ? 16'h0004 : 16'h0000;
            wr_data = 8'h77;
            step();
            rd_en = 1'b0;
            wr_en = 1'b0;
            sel = 16'h0000;
            if (k == 3) begin
                checks++;
                if (rd_data !== 8'h1F || rd_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL sweep_read_15 got %h/%b expected 1f/1", rd_data, rd_valid);
                end
            end
            if (k == 5) begin
                checks++;
                if (wr_drop !== 1'b1 || err_sel !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_wr_drop got %b/%b expected 1/0", wr_drop, err_sel);
                end
            end
            if (busy === 1'b1) begin
                busy_cnt++;
            end else begin
                if (clr_done === 1'b1) done_seen = 1;
                break;
            end
        end
        checks++;
        if (busy_cnt != 16 || done_seen != 1) begin
            errors++;
            $display("FAIL sweep_busy_len got %0d/%0d expected 16/1", busy_cnt, done_seen);
        end
        step();
        checks++;
        if (clr_done !== 1'b0 || busy !== 1'b0 || wr_drop !== 1'b0) begin
            errors++;
            $display("FAIL sweep_done_pulse got %b/%b/%b expected 0/0/0", clr_done, busy, wr_drop);
        end
        for (int i = 0; i < 16; i++) begin
            do_read(4'(i), d, v);
            checks++;
            if (d !== 8'h00) begin
                errors++;
                $display("FAIL cleared[%0d] got %h expected 00", i, d);
            end
        end
    endtask

    task automatic test_read_before_write();
        logic [7:0] d;
        logic       v;
        do_write(7, 8'h11);
        sel     = 16'h0080;
        wr_en   = 1'b1;
        wr_data = 8'h3C;
        rd_en   = 1'b1;
        rd_addr = 4'd7;
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        sel   = 16'h0000;
        checks++;
        if (rd_data !== 8'h11) begin
            errors++;
            $display("FAIL rbw_old got %h expected 11", rd_data);
        end
        do_read(4'd7, d, v);
        checks++;
        if (d !== 8'h3C) begin
            errors++;
            $display("FAIL rbw_new got %h expected 3c", d);
        end
    endtask

    task automatic test_clr_with_write();
        logic [7:0] d;
        logic       v;
        int         guard;
        sel     = 16'h0001;
        wr_en   = 1'b1;
        wr_data = 8'h55;
        clr_req = 1'b1;
        step();
        wr_en   = 1'b0;
        sel     = 16'h0000;
        clr_req = 1'b0;
        do_read(4'd0, d, v);
        checks++;
        if (d !== 8'h55 || busy !== 1'b1) begin
            errors++;
            $display("FAIL clr_write_commit got %h/%b expected 55/1", d, busy);
        end
        guard = 0;
        while (clr_done !== 1'b1 && guard < 40) begin
            step();
            guard++;
        end
        do_read(4'd0, d, v);
        checks++;
        if (d !== 8'h00 || guard >= 40) begin
            errors++;
            $display("FAIL clr_write_cleared got %h (wait %0d) expected 00", d, guard);
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic [7:0] d;
        logic       v;
        int         done_cnt;
        do_write(12, 8'hC3);
        do_write(3, 8'h99);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int k = 0; k < 8; k++) step();
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL async_reset_busy got %b/%h expected 0/00", busy, rd_data);
        end
        step();
        reset = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (clr_done === 1'b1 || busy === 1'b1) done_cnt++;
        end
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL reset_no_done got %0d expected 0", done_cnt);
        end
        do_read(4'd12, d, v);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL reset_entry_12 got %h expected 00", d);
        end
        do_read(4'd7, d, v);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL reset_entry_7 got %h expected 00", d);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        sel     = 16'h0000;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        rd_en   = 1'b0;
        rd_addr = 4'd0;
        clr_req = 1'b0;
        test_reset();
        test_reset_read_all();
        test_write_read();
        test_err_sel();
        test_clear_sweep();
        test_read_before_write();
        test_clr_with_write();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
